// File: rtl/alt_vipvfr121_pkg.sv
// ============================================================================
// Module      : alt_vipvfr121_pkg
// Description : Shared constants for the packet writer core: master address
//               width, FSM state encoding and the video packet type nibble.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alt_vipvfr121_pkg;

    localparam int ADDR_WIDTH = 32;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_SOP = 3'd1;
    localparam logic [STATE_W-1:0] ST_CMD      = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUNNING  = 3'd3;
    localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd5;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

endpackage

`default_nettype wire

// File: rtl/alt_vipvfr121_pwc_sample_counter.sv
// ============================================================================
// Module      : alt_vipvfr121_pwc_sample_counter
// Description : Saturating payload-beat counter with limit compare. trunc_o is
//               high once the count has reached the programmed limit (a limit
//               of zero truncates immediately).
// Ports       : clk, rst_n (async, active low), clr_i (synchronous clear),
//               inc_i (count one beat), limit_i, count_o, trunc_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipvfr121_pwc_sample_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             trunc_o
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            // Holds at all-ones rather than wrapping back to zero.
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign trunc_o = (count_q >= limit_i);

endmodule

`default_nettype wire

// File: rtl/alt_vipvfr121_pwc_core.sv
// ============================================================================
// Module      : alt_vipvfr121_pwc_core
// Description : Packet writer core. On each GO it accepts one Avalon-ST video
//               packet, issues one write-master burst command and streams the
//               payload beats to the packer, then flushes and pulses complete.
// Ports       : clock/reset (async, active low); ST sink (valid_in, ready_in,
//               data_in, sop_in, eop_in); command (cmd, cmd_ready, cmd_addr,
//               cmd_length_of_burst); data (write, wdata, write_ready, flush,
//               flush_ready); register block (enable, clear_enable, stopped,
//               complete, overflow, packet_addr, packet_words, packet_samples,
//               packet_type, samples_written)
// Options     : PWC_DROP_NON_VIDEO_EN - discard packets whose type nibble is
//               not video instead of writing them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alt_vipvfr121_pwc_core
    import alt_vipvfr121_pkg::*;
#(
    parameter int BITS_PER_SYMBOL              = 8,
    parameter int SYMBOLS_PER_BEAT             = 3,
    parameter int BURST_LENGTH_REQUIREDWIDTH   = 7,
    parameter int PACKET_SAMPLES_REQUIREDWIDTH = 32
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
    input  logic                                    sop_in,
    input  logic                                    eop_in,
    output logic                                    cmd,
    input  logic                                    cmd_ready,
    output logic [ADDR_WIDTH-1:0]                   cmd_addr,
    output logic [BURST_LENGTH_REQUIREDWIDTH-1:0]   cmd_length_of_burst,
    output logic                                    write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] wdata,
    input  logic                                    write_ready,
    output logic                                    flush,
    input  logic                                    flush_ready,
    input  logic                                    enable,
    output logic                                    clear_enable,
    output logic                                    stopped,
    output logic                                    complete,
    output logic                                    overflow,
    input  logic [ADDR_WIDTH-1:0]                   packet_addr,
    input  logic [BURST_LENGTH_REQUIREDWIDTH-1:0]   packet_words,
    input  logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0] packet_samples,
    output logic [3:0]                              packet_type,
    output logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0] samples_written
);

    logic [STATE_W-1:0]                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
    logic [BURST_LENGTH_REQUIREDWIDTH-1:0]   words_q, words_d;
    logic [PACKET_SAMPLES_REQUIREDWIDTH-1:0] limit_q, limit_d;
    logic [3:0]                              ptype_q, ptype_d;
    logic                                    overflow_q, overflow_d;
    logic                                    clr_en_q, clr_en_d;

    logic w_go;
    logic w_sop_beat;
    logic w_trunc;
    logic w_drop_type;

    assign w_go       = (state_q == ST_IDLE) && enable;
    assign w_sop_beat = valid_in && sop_in;

`ifdef PWC_DROP_NON_VIDEO_EN
    // Non-video packets stay in WAIT_SOP, where their remaining beats are
    // swallowed as ordinary pre-SOP beats.
    assign w_drop_type = (data_in[3:0] != PKT_TYPE_VIDEO);
`else
    assign w_drop_type = 1'b0;
`endif

    alt_vipvfr121_pwc_sample_counter #(
        .WIDTH (PACKET_SAMPLES_REQUIREDWIDTH)
    ) u_sample_counter (
        .clk     (clock),
        .rst_n   (reset),
        .clr_i   (w_go),
        .inc_i   (write && write_ready),
        .limit_i (limit_q),
        .count_o (samples_written),
        .trunc_o (w_trunc)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_WAIT_SOP;
            end
            ST_WAIT_SOP: begin
                if (w_sop_beat && !w_drop_type) begin
                    // A header-only packet carries no payload to write.
                    state_d = eop_in ? ST_FLUSH : ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_ready) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                // A fresh SOP ends the packet early; it is left unaccepted.
                if (w_sop_beat) begin
                    state_d = ST_FLUSH;
                end else if (valid_in && eop_in && ready_in) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic.
    always_comb begin
        ready_in = 1'b0;
        cmd      = 1'b0;
        write    = 1'b0;
        flush    = 1'b0;
        complete = 1'b0;
        stopped  = 1'b0;
        case (state_q)
            ST_IDLE:     stopped  = 1'b1;
            ST_WAIT_SOP: ready_in = 1'b1;
            ST_CMD:      cmd      = 1'b1;
            ST_RUNNING: begin
                if (!w_sop_beat) begin
                    // Once truncated, beats are still consumed but not written.
                    write    = valid_in && !w_trunc;
                    ready_in = w_trunc || write_ready;
                end
            end
            ST_FLUSH:    flush    = 1'b1;
            ST_DONE: begin
                complete = 1'b1;
                stopped  = 1'b1;
            end
            default: ;
        endcase
    end

    // Register-block datapath.
    always_comb begin
        addr_d     = addr_q;
        words_d    = words_q;
        limit_d    = limit_q;
        ptype_d    = ptype_q;
        overflow_d = overflow_q;
        clr_en_d   = w_go;
        if (w_go) begin
            addr_d     = packet_addr;
            words_d    = packet_words;
            limit_d    = packet_samples;
            overflow_d = 1'b0;
        end
        if ((state_q == ST_WAIT_SOP) && w_sop_beat) begin
            ptype_d = data_in[3:0];
        end
        if ((state_q == ST_RUNNING) && (w_trunc || w_sop_beat)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            words_q    <= '0;
            limit_q    <= '0;
            ptype_q    <= '0;
            overflow_q <= 1'b0;
            clr_en_q   <= 1'b1;
        end else begin
            addr_q     <= addr_d;
            words_q    <= words_d;
            limit_q    <= limit_d;
            ptype_q    <= ptype_d;
            overflow_q <= overflow_d;
            clr_en_q   <= clr_en_d;
        end
    end

    assign wdata               = data_in;
    assign cmd_addr            = addr_q;
    assign cmd_length_of_burst = words_q;
    assign packet_type         = ptype_q;
    assign overflow            = overflow_q;
    assign clear_enable        = clr_en_q;

endmodule

`default_nettype wire

// File: tb/tb_alt_vipvfr121_pwc_core.sv
// ============================================================================
// Module      : tb_alt_vipvfr121_pwc_core
// Description : Self-checking bench for alt_vipvfr121_pwc_core. Packets use
//               random payload data; expected writes, sample count and
//               overflow come from a packet-level model of the writer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alt_vipvfr121_pwc_core;

    localparam int DW  = 24;
    localparam int BLW = 7;
    localparam int PSW = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           valid_in = 1'b0;
    logic           ready_in;
    logic [DW-1:0]  data_in = '0;
    logic           sop_in = 1'b0;
    logic           eop_in = 1'b0;
    logic           cmd;
    logic           cmd_ready = 1'b1;
    logic [31:0]    cmd_addr;
    logic [BLW-1:0] cmd_length_of_burst;
    logic           write;
    logic [DW-1:0]  wdata;
    logic           write_ready = 1'b1;
    logic           flush;
    logic           flush_ready = 1'b1;
    logic           enable = 1'b0;
    logic           clear_enable;
    logic           stopped;
    logic           complete;
    logic           overflow;
    logic [31:0]    packet_addr = '0;
    logic [BLW-1:0] packet_words = '0;
    logic [PSW-1:0] packet_samples = '0;
    logic [3:0]     packet_type;
    logic [PSW-1:0] samples_written;

    alt_vipvfr121_pwc_core dut (
        .clock               (clock),
        .reset               (reset),
        .valid_in            (valid_in),
        .ready_in            (ready_in),
        .data_in             (data_in),
        .sop_in              (sop_in),
        .eop_in              (eop_in),
        .cmd                 (cmd),
        .cmd_ready           (cmd_ready),
        .cmd_addr            (cmd_addr),
        .cmd_length_of_burst (cmd_length_of_burst),
        .write               (write),
        .wdata               (wdata),
        .write_ready         (write_ready),
        .flush               (flush),
        .flush_ready         (flush_ready),
        .enable              (enable),
        .clear_enable        (clear_enable),
        .stopped             (stopped),
        .complete            (complete),
        .overflow            (overflow),
        .packet_addr         (packet_addr),
        .packet_words        (packet_words),
        .packet_samples      (packet_samples),
        .packet_type         (packet_type),
        .samples_written     (samples_written)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int n_to  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Backpressure generator: all-ready unless rand_mode is set.
    bit rand_mode = 1'b0;
    always @(negedge clock) begin
        if (rand_mode) begin
            write_ready = 1'($urandom_range(0, 1));
            cmd_ready   = 1'($urandom_range(0, 1));
            flush_ready = 1'($urandom_range(0, 1));
        end else begin
            write_ready = 1'b1;
            cmd_ready   = 1'b1;
            flush_ready = 1'b1;
        end
    end

    // Observer: sampled mid-low-phase, i.e. the values the next edge will see.
    logic [DW-1:0]  wq[$];
    int             n_cmdacc = 0;
    int             n_flush = 0;
    int             n_compl = 0;
    int             n_cmd_drop = 0;
    logic [31:0]    seen_addr = '0;
    logic [BLW-1:0] seen_len = '0;
    logic           cmd_pend = 1'b0;

    always @(negedge clock) begin
        #2;
        if (reset) begin
            if (write && write_ready) wq.push_back(wdata);
            if (cmd && cmd_ready) begin
                n_cmdacc++;
                seen_addr = cmd_addr;
                seen_len  = cmd_length_of_burst;
            end
            if (cmd_pend && !cmd) n_cmd_drop++;
            cmd_pend = cmd && !cmd_ready;
            if (flush && flush_ready) n_flush++;
            if (complete) n_compl++;
        end else begin
            cmd_pend = 1'b0;
        end
    end

    task automatic clear_obs();
        wq.delete();
        n_cmdacc   = 0;
        n_flush    = 0;
        n_compl    = 0;
        n_cmd_drop = 0;
    endtask

    task automatic go(input logic [31:0] a, input logic [BLW-1:0] w, input logic [PSW-1:0] s);
        clear_obs();
        packet_addr    = a;
        packet_words   = w;
        packet_samples = s;
        enable         = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        #1;
        check("clear_enable_pulse", clear_enable, 1);
        check("stopped_after_go", stopped, 0);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
        bit ok;
        ok = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        sop_in   = s;
        eop_in   = e;
        for (int t = 0; t < 400; t++) begin
            #1;
            if (ready_in) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) n_to++;
        @(negedge clock);
        valid_in = 1'b0;
        sop_in   = 1'b0;
        eop_in   = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            #3;
            if (n_compl > 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) n_to++;
        repeat (3) @(negedge clock);
    endtask

    // One packet: npre junk beats, SOP(type ty), then either npay payload
    // beats ending in eop, or (early>0) early beats followed by a new SOP.
    task automatic run_packet(input string nm, input bit do_go, input logic [31:0] a,
                              input logic [BLW-1:0] w, input logic [PSW-1:0] lim,
                              input logic [3:0] ty, input int npay, input int npre,
                              input int early);
        logic [DW-1:0] pay[$];
        logic [DW-1:0] hdr;
        int nsent, nexp;
        bit ovf;
        if (do_go) go(a, w, lim);
        for (int i = 0; i < npre; i++) send_beat(DW'($urandom), 1'b0, 1'b0);
        hdr = DW'($urandom);
        hdr[3:0] = ty;
        send_beat(hdr, 1'b1, (npay == 0));
        nsent = (early > 0) ? early : npay;
        for (int i = 0; i < nsent; i++) pay.push_back(DW'($urandom));
        for (int i = 0; i < nsent; i++)
            send_beat(pay[i], 1'b0, (early == 0) && (i == nsent - 1));
        if (early > 0) begin
            hdr = DW'($urandom);
            hdr[3:0] = 4'h0;
            valid_in = 1'b1;
            data_in  = hdr;
            sop_in   = 1'b1;
            #1;
            check({nm, "_sop_stall"}, ready_in, 0);
        end
        wait_done();
        valid_in = 1'b0;
        sop_in   = 1'b0;

        // Packet-level expectation.
        nexp = (longint'(nsent) < longint'(lim)) ? nsent : int'(lim);
        ovf  = (early > 0) || (longint'(nsent) > longint'(lim));
        if (npay == 0) begin
            nexp = 0;
            ovf  = 1'b0;
        end
        check({nm, "_cmd_count"}, n_cmdacc, (npay == 0) ? 0 : 1);
        if (npay != 0) begin
            check({nm, "_cmd_addr"}, seen_addr, a);
            check({nm, "_cmd_len"}, seen_len, w);
        end
        check({nm, "_write_count"}, wq.size(), nexp);
        for (int i = 0; i < nexp && i < wq.size(); i++)
            check({nm, "_wdata"}, wq[i], pay[i]);
        check({nm, "_flush_count"}, n_flush, 1);
        check({nm, "_complete_pulses"}, n_compl, 1);
        check({nm, "_samples_written"}, samples_written, nexp);
        check({nm, "_overflow"}, overflow, ovf);
        check({nm, "_packet_type"}, packet_type, ty);
        check({nm, "_stopped"}, stopped, 1);
        check({nm, "_cmd_held"}, n_cmd_drop, 0);
        check({nm, "_timeouts"}, n_to, 0);
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_ready_in"}, ready_in, 0);
        check({nm, "_cmd"}, cmd, 0);
        check({nm, "_write"}, write, 0);
        check({nm, "_flush"}, flush, 0);
        check({nm, "_clear_enable"}, clear_enable, 1);
        check({nm, "_stopped"}, stopped, 1);
        check({nm, "_complete"}, complete, 0);
        check({nm, "_overflow"}, overflow, 0);
        check({nm, "_packet_type"}, packet_type, 0);
        check({nm, "_samples"}, samples_written, 0);
        check({nm, "_cmd_addr"}, cmd_addr, 0);
        check({nm, "_cmd_len"}, cmd_length_of_burst, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("idle_clear_enable_low", clear_enable, 0);
        @(negedge clock);

        run_packet("basic", 1'b1, 32'h0000_1000, 7'd4, 32'd6, 4'h0, 6, 0, 0);
        run_packet("trunc", 1'b1, 32'h0000_1100, 7'd3, 32'd4, 4'h0, 7, 0, 0);

        rand_mode = 1'b1;
        run_packet("random_bp", 1'b1, 32'h0000_3000, 7'd4, 32'd6, 4'h0, 6, 0, 0);
        run_packet("random_bp2", 1'b1, 32'h0000_3400, 7'd9, 32'd5, 4'h0, 8, 1, 0);
        rand_mode = 1'b0;
        @(negedge clock);

`ifdef PWC_DROP_NON_VIDEO_EN
        go(32'h0000_4000, 7'd2, 32'd6);
        send_beat(DW'($urandom), 1'b0, 1'b0);
        send_beat(DW'($urandom), 1'b0, 1'b0);
        send_beat(24'h0000AF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(DW'($urandom), 1'b0, (i == 3));
        repeat (4) @(negedge clock);
        #3;
        check("drop_nv_no_cmd", n_cmdacc, 0);
        check("drop_nv_no_complete", n_compl, 0);
        check("drop_nv_not_stopped", stopped, 0);
        run_packet("drop_nv_video", 1'b0, 32'h0000_4000, 7'd2, 32'd6, 4'h0, 5, 0, 0);
`else
        run_packet("pre_sop_typeF", 1'b1, 32'h0000_4000, 7'd2, 32'd6, 4'hF, 5, 2, 0);
`endif

        run_packet("early_sop", 1'b1, 32'h0000_5000, 7'd4, 32'd6, 4'h0, 6, 0, 3);
        run_packet("hdr_only", 1'b1, 32'h0000_6000, 7'd1, 32'd6, 4'h0, 0, 0, 0);
        run_packet("limit0", 1'b1, 32'h0000_7000, 7'd1, 32'd0, 4'h0, 3, 0, 0);

        // Asynchronous reset in the middle of a packet.
        go(32'h0000_8000, 7'd4, 32'd6);
        send_beat(24'h000000, 1'b1, 1'b0);
        send_beat(DW'($urandom), 1'b0, 1'b0);
        send_beat(DW'($urandom), 1'b0, 1'b0);
        valid_in = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        valid_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_packet("after_rst", 1'b1, 32'h0000_9000, 7'd4, 32'd6, 4'h0, 6, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
